// File: rtl/mod_147_11_sync_pkg.sv
// Shared encodings for the mod_147_11_sync link-status FSM: states, rx_cmd codes, status values.
package mod_147_11_sync_pkg;

    localparam logic [2:0] ST_INACTIVE   = 3'b000;
    localparam logic [2:0] ST_COUNT_DOWN = 3'b001;
    localparam logic [2:0] ST_COUNT_UP   = 3'b010;
    localparam logic [2:0] ST_HOLD_OFF   = 3'b011;
    localparam logic [2:0] ST_ACTIVE     = 3'b100;
    localparam logic [2:0] ST_HOLD_ON    = 3'b101;

    localparam logic [1:0] CMD_BEACON    = 2'b00;
    localparam logic [1:0] CMD_COMMIT    = 2'b01;
    localparam logic [1:0] CMD_HEARTBEAT = 2'b10;
    localparam logic [1:0] CMD_NONE      = 2'b11;

    localparam logic PCS_OK     = 1'b1;
    localparam logic PCS_NOT_OK = 1'b0;

endpackage

// File: rtl/link_hold_tmr.sv
// Link-hold timer: restart zeroes the count; done rises hold_ticks cycles later (0 acts as 1)
// and stays high until the next restart.
module link_hold_tmr #(
    parameter int TMR_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic [TMR_W-1:0] hold_ticks,
    output logic             done
);

    localparam logic [TMR_W-1:0] ONE = {{(TMR_W-1){1'b0}}, 1'b1};

    logic [TMR_W-1:0] cnt_q, cnt_d, limit;
    logic             done_q, done_d;

    always_comb begin
        limit  = (hold_ticks == '0) ? '0 : hold_ticks - ONE;
        cnt_d  = cnt_q;
        done_d = done_q;
        if (restart) begin
            cnt_d  = '0;
            done_d = 1'b0;
        end else begin
            // Count saturates so a long idle period can never re-arm the flag.
            if (cnt_q != '1) cnt_d = cnt_q + ONE;
            if (cnt_q >= limit) done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;

endmodule

// File: rtl/mod_147_11_sync.sv
// Heartbeat-driven PCS link-status FSM with link-hold timer and status-change pulse.
// Optional macro PCS_STATUS_STATS_EN enables the link_up_cnt/link_down_cnt statistics.
module mod_147_11_sync
    import mod_147_11_sync_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int TMR_W = 16
) (
    input  logic             clk,
    input  logic             pcs_reset,
    input  logic             mr_autoneg_enable,
    input  logic             an_link_good,
    input  logic             multidrop,
    input  logic [1:0]       rx_cmd,
    input  logic             RX_DV,
    input  logic             CRS,
    input  logic [CNT_W-1:0] ACTIVE_CNT,
    input  logic [CNT_W-1:0] INACTIVE_CNT,
    input  logic [TMR_W-1:0] hold_ticks,
    output logic [2:0]       mod_147_11_state,
    output logic             pcs_status,
    output logic [CNT_W-1:0] cnt_h,
    output logic [CNT_W-1:0] cnt_l,
    output logic             link_hold_timer_done,
    output logic             status_chg,
    output logic [15:0]      link_up_cnt,
    output logic [15:0]      link_down_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       state_q, state_d;
    logic             status_q, status_d, status_prev_q, status_chg_q;
    logic [CNT_W-1:0] cnt_h_q, cnt_h_d, cnt_l_q, cnt_l_d;
    logic             force_in, hb, rx_quiet, entering, tmr_restart, tmr_done;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_ONE;
    endfunction

    always_comb begin
        force_in = pcs_reset | ~mr_autoneg_enable | ~an_link_good | multidrop;
        hb       = (rx_cmd == CMD_HEARTBEAT) | RX_DV;
        rx_quiet = (rx_cmd == CMD_NONE) & ~RX_DV;
        state_d  = state_q;
        case (state_q)
            ST_INACTIVE:   if (hb) state_d = ST_COUNT_UP;
            ST_COUNT_UP: begin
                if (cnt_h_q >= ACTIVE_CNT)  state_d = ST_ACTIVE;
                else if (rx_quiet & ~CRS)   state_d = ST_HOLD_OFF;
            end
            ST_HOLD_OFF: begin
                if (hb)                          state_d = ST_COUNT_UP;
                else if (tmr_done & rx_quiet)    state_d = ST_INACTIVE;
            end
            ST_ACTIVE: begin
                if (hb)            state_d = ST_HOLD_ON;
                else if (tmr_done) state_d = ST_COUNT_DOWN;
            end
            ST_HOLD_ON:    if (rx_quiet) state_d = ST_ACTIVE;
            ST_COUNT_DOWN: state_d = (cnt_l_q >= INACTIVE_CNT) ? ST_INACTIVE : ST_ACTIVE;
            default:       state_d = ST_INACTIVE;
        endcase
        if (force_in) state_d = ST_INACTIVE;
    end

    // Entry actions fire on the edge that enters a state; INACTIVE re-applies its clears every cycle.
    always_comb begin
        entering    = (state_d != state_q);
        status_d    = status_q;
        cnt_h_d     = cnt_h_q;
        cnt_l_d     = cnt_l_q;
        tmr_restart = 1'b0;
        if (state_d == ST_INACTIVE) begin
            status_d = PCS_NOT_OK;
            cnt_h_d  = '0;
            cnt_l_d  = '0;
        end else if (entering) begin
            case (state_d)
                ST_COUNT_UP: begin
                    cnt_h_d     = sat_inc(cnt_h_q);
                    tmr_restart = 1'b1;
                end
                ST_ACTIVE: begin
                    status_d    = PCS_OK;
                    tmr_restart = 1'b1;
                end
                ST_HOLD_ON:    cnt_l_d = '0;
                ST_COUNT_DOWN: cnt_l_d = sat_inc(cnt_l_q);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (pcs_reset) begin
            state_q       <= ST_INACTIVE;
            status_q      <= PCS_NOT_OK;
            status_prev_q <= PCS_NOT_OK;
            status_chg_q  <= 1'b0;
            cnt_h_q       <= '0;
            cnt_l_q       <= '0;
        end else begin
            state_q       <= state_d;
            status_q      <= status_d;
            status_prev_q <= status_q;
            status_chg_q  <= status_q ^ status_prev_q;
            cnt_h_q       <= cnt_h_d;
            cnt_l_q       <= cnt_l_d;
        end
    end

    link_hold_tmr #(.TMR_W(TMR_W)) u_tmr (
        .clk        (clk),
        .rst        (pcs_reset),
        .restart    (tmr_restart),
        .hold_ticks (hold_ticks),
        .done       (tmr_done)
    );

`ifdef PCS_STATUS_STATS_EN
    logic [15:0] up_q, down_q;

    // Transitions are counted alongside the status_chg pulse, so a reset never counts as a drop.
    always_ff @(posedge clk) begin
        if (pcs_reset) begin
            up_q   <= '0;
            down_q <= '0;
        end else begin
            if (status_q & ~status_prev_q & (up_q != 16'hFFFF))   up_q   <= up_q + 16'd1;
            if (~status_q & status_prev_q & (down_q != 16'hFFFF)) down_q <= down_q + 16'd1;
        end
    end

    assign link_up_cnt   = up_q;
    assign link_down_cnt = down_q;
`else
    assign link_up_cnt   = '0;
    assign link_down_cnt = '0;
`endif

    assign mod_147_11_state     = state_q;
    assign pcs_status           = status_q;
    assign cnt_h                = cnt_h_q;
    assign cnt_l                = cnt_l_q;
    assign link_hold_timer_done = tmr_done;
    assign status_chg           = status_chg_q;

endmodule

// File: tb/tb_mod_147_11_sync.sv
// Bench for mod_147_11_sync: directed scenarios plus randomized traffic against a cycle reference model.
module tb_mod_147_11_sync;

    logic        clk = 1'b0;
    logic        pcs_reset, mr_autoneg_enable, an_link_good, multidrop;
    logic [1:0]  rx_cmd;
    logic        RX_DV, CRS;
    logic [7:0]  ACTIVE_CNT, INACTIVE_CNT;
    logic [15:0] hold_ticks;

    logic [2:0]  st;
    logic        status, done, chg;
    logic [7:0]  h, l;
    logic [15:0] up, down;

    logic [2:0]  st4;
    logic        status4, done4, chg4;
    logic [3:0]  h4, l4;
    logic [15:0] up4, down4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mod_147_11_sync dut (
        .clk(clk), .pcs_reset(pcs_reset), .mr_autoneg_enable(mr_autoneg_enable),
        .an_link_good(an_link_good), .multidrop(multidrop), .rx_cmd(rx_cmd),
        .RX_DV(RX_DV), .CRS(CRS), .ACTIVE_CNT(ACTIVE_CNT), .INACTIVE_CNT(INACTIVE_CNT),
        .hold_ticks(hold_ticks), .mod_147_11_state(st), .pcs_status(status),
        .cnt_h(h), .cnt_l(l), .link_hold_timer_done(done), .status_chg(chg),
        .link_up_cnt(up), .link_down_cnt(down)
    );

    mod_147_11_sync #(.CNT_W(4), .TMR_W(16)) dut4 (
        .clk(clk), .pcs_reset(pcs_reset), .mr_autoneg_enable(mr_autoneg_enable),
        .an_link_good(an_link_good), .multidrop(multidrop), .rx_cmd(rx_cmd),
        .RX_DV(RX_DV), .CRS(CRS), .ACTIVE_CNT(ACTIVE_CNT[3:0]), .INACTIVE_CNT(INACTIVE_CNT[3:0]),
        .hold_ticks(hold_ticks), .mod_147_11_state(st4), .pcs_status(status4),
        .cnt_h(h4), .cnt_l(l4), .link_hold_timer_done(done4), .status_chg(chg4),
        .link_up_cnt(up4), .link_down_cnt(down4)
    );

    // Reference model: spec-level rules, timer kept as "cycles since restart".
    logic [2:0]  m_state = 3'd0;
    logic        m_status = 1'b0, m_prev = 1'b0, m_chg = 1'b0, m_done = 1'b0;
    logic [7:0]  m_h = 8'd0, m_l = 8'd0;
    logic [15:0] m_up = 16'd0, m_down = 16'd0;
    int          m_elapsed = 0;

    always @(posedge clk) begin : ref_model
        logic [2:0] nx;
        logic [7:0] nh, nl;
        logic       ns, hbm, quiet, rs;
        int         lim, el;
        lim   = (hold_ticks == 16'd0) ? 1 : int'(hold_ticks);
        hbm   = (rx_cmd == 2'b10) || RX_DV;
        quiet = (rx_cmd == 2'b11) && !RX_DV;
        nh = m_h; nl = m_l; ns = m_status; rs = 1'b0; nx = m_state;
        if (pcs_reset) begin
            m_state <= 3'd0; m_status <= 1'b0; m_prev <= 1'b0; m_chg <= 1'b0;
            m_h <= 8'd0; m_l <= 8'd0; m_elapsed <= 0; m_done <= 1'b0;
            m_up <= 16'd0; m_down <= 16'd0;
        end else begin
            if (m_state == 3'd0)      nx = hbm ? 3'd2 : 3'd0;
            else if (m_state == 3'd2) nx = (m_h >= ACTIVE_CNT) ? 3'd4 : ((quiet && !CRS) ? 3'd3 : 3'd2);
            else if (m_state == 3'd3) nx = hbm ? 3'd2 : ((m_done && quiet) ? 3'd0 : 3'd3);
            else if (m_state == 3'd4) nx = hbm ? 3'd5 : (m_done ? 3'd1 : 3'd4);
            else if (m_state == 3'd5) nx = quiet ? 3'd4 : 3'd5;
            else if (m_state == 3'd1) nx = (m_l >= INACTIVE_CNT) ? 3'd0 : 3'd4;
            else                      nx = 3'd0;
            if (!mr_autoneg_enable || !an_link_good || multidrop) nx = 3'd0;
            if (nx == 3'd0) begin
                nh = 8'd0; nl = 8'd0; ns = 1'b0;
            end else if (nx != m_state) begin
                if (nx == 3'd2) begin nh = (m_h == 8'hFF) ? m_h : m_h + 8'd1; rs = 1'b1; end
                if (nx == 3'd4) begin ns = 1'b1; rs = 1'b1; end
                if (nx == 3'd5) nl = 8'd0;
                if (nx == 3'd1) nl = (m_l == 8'hFF) ? m_l : m_l + 8'd1;
            end
            el = rs ? 0 : m_elapsed + 1;
            m_elapsed <= el;
            m_done    <= (el >= lim);
            m_chg     <= (m_status != m_prev);
            m_prev    <= m_status;
            if (m_status && !m_prev) m_up <= m_up + 16'd1;
            if (!m_status && m_prev) m_down <= m_down + 16'd1;
            m_status <= ns; m_h <= nh; m_l <= nl; m_state <= nx;
        end
    end

`ifdef PCS_STATUS_STATS_EN
    wire [15:0] exp_up = m_up, exp_down = m_down;
    localparam int STATS_ON = 1;
`else
    wire [15:0] exp_up = 16'd0, exp_down = 16'd0;
    localparam int STATS_ON = 0;
`endif

    wire [53:0] dut_vec = {st, status, h, l, done, chg, up, down};
    wire [53:0] exp_vec = {m_state, m_status, m_h, m_l, m_done, m_chg, exp_up, exp_down};

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        mr_autoneg_enable = 1'b1; an_link_good = 1'b1; multidrop = 1'b0;
        rx_cmd = 2'b11; RX_DV = 1'b0; CRS = 1'b0;
    endtask

    task automatic do_reset();
        pcs_reset = 1'b1;
        step();
        step();
        pcs_reset = 1'b0;
    endtask

    task automatic test_reset();
        hold_ticks = 16'd4; ACTIVE_CNT = 8'd3; INACTIVE_CNT = 8'd2;
        idle();
        do_reset();
        n_checks++;
        if (dut_vec !== 54'd0) begin
            n_errors++; $display("FAIL reset_outputs got=%h exp=%h", dut_vec, 54'd0);
        end
        n_checks++;
        if ({st4, status4, h4, l4, done4, chg4, up4, down4} !== 46'd0) begin
            n_errors++; $display("FAIL reset_outputs_w4 got=%h exp=0", {st4, status4, h4, l4, done4, chg4, up4, down4});
        end
        n_checks++;
        if (dut_vec !== exp_vec) begin
            n_errors++; $display("FAIL reset_model got=%h exp=%h", dut_vec, exp_vec);
        end
    endtask

    task automatic test_activate();
        hold_ticks = 16'd4; ACTIVE_CNT = 8'd3;
        idle();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            rx_cmd = 2'b10; step();
            n_checks++;
            if (st !== 3'd2 || h !== 8'(i + 1)) begin
                n_errors++; $display("FAIL activate_countup st=%0d h=%0d exp st=2 h=%0d", st, h, i + 1);
            end
            rx_cmd = 2'b11; step();
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_errors++; $display("FAIL activate_model got=%h exp=%h", dut_vec, exp_vec);
            end
        end
        n_checks++;
        if (st !== 3'd4 || status !== 1'b1 || chg !== 1'b0) begin
            n_errors++; $display("FAIL activate_enter st=%0d status=%0d chg=%0d exp 4/1/0", st, status, chg);
        end
        step();
        n_checks++;
        if (chg !== 1'b1 || st !== 3'd4) begin
            n_errors++; $display("FAIL activate_chg_pulse chg=%0d st=%0d exp 1/4", chg, st);
        end
        step();
        n_checks++;
        if (chg !== 1'b0) begin
            n_errors++; $display("FAIL activate_chg_width chg=%0d exp 0", chg);
        end
    endtask

    task automatic test_count_down();
        int cd = 0;
        bit reached = 0;
        INACTIVE_CNT = 8'd2;
        rx_cmd = 2'b11;
        for (int i = 0; i < 40 && !reached; i++) begin
            step();
            n_checks++;
            if (dut_vec !== exp_vec) begin
                n_errors++; $display("FAIL countdown_model cyc=%0d got=%h exp=%h", i, dut_vec, exp_vec);
            end
            if (st == 3'd1) cd++;
            if (st == 3'd0) reached = 1;
        end
        n_checks++;
        if (!reached || cd != 2 || status !== 1'b0) begin
            n_errors++; $display("FAIL countdown_result reached=%0d cd=%0d status=%0d exp 1/2/0", reached, cd, status);
        end
        step();
        n_checks++;
        if (chg !== 1'b1) begin
            n_errors++; $display("FAIL countdown_chg chg=%0d exp 1", chg);
        end
    endtask

    task automatic test_link_drop();
        bit seen = 0;
        hold_ticks = 16'd4; ACTIVE_CNT = 8'd1; INACTIVE_CNT = 8'd2;
        idle();
        do_reset();
        rx_cmd = 2'b10; step();
        rx_cmd = 2'b11; step();
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (st == 3'd1) seen = 1;
        end
        step();
        n_checks++;
        if (!seen || st !== 3'd4 || l !== 8'd1 || h !== 8'd1) begin
            n_errors++; $display("FAIL linkdrop_setup seen=%0d st=%0d h=%0d l=%0d exp 1/4/1/1", seen, st, h, l);
        end
        an_link_good = 1'b0; step();
        an_link_good = 1'b1;
        n_checks++;
        if (st !== 3'd0 || h !== 8'd0 || l !== 8'd0 || status !== 1'b0) begin
            n_errors++; $display("FAIL linkdrop_force st=%0d h=%0d l=%0d status=%0d exp all 0", st, h, l, status);
        end
        step();
        n_checks++;
        if (chg !== 1'b1 || dut_vec !== exp_vec) begin
            n_errors++; $display("FAIL linkdrop_chg got=%h exp=%h", dut_vec, exp_vec);
        end
    endtask

    task automatic test_hb_vs_done();
        bit got = 0;
        hold_ticks = 16'd2; ACTIVE_CNT = 8'd1; INACTIVE_CNT = 8'd2;
        idle();
        do_reset();
        rx_cmd = 2'b10; step();
        rx_cmd = 2'b11; step();
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (done === 1'b1) got = 1;
        end
        n_checks++;
        if (!got || st !== 3'd4) begin
            n_errors++; $display("FAIL hbdone_setup done=%0d st=%0d exp 1/4", got, st);
        end
        rx_cmd = 2'b10; step();
        n_checks++;
        if (st !== 3'd5 || l !== 8'd0) begin
            n_errors++; $display("FAIL hbdone_priority st=%0d l=%0d exp 5/0", st, l);
        end
        rx_cmd = 2'b11; step();
        n_checks++;
        if (st !== 3'd4 || done !== 1'b0) begin
            n_errors++; $display("FAIL hbdone_restart st=%0d done=%0d exp 4/0", st, done);
        end
        pcs_reset = 1'b1; step();
        pcs_reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (chg !== 1'b0 || status !== 1'b0) begin
                n_errors++; $display("FAIL reset_no_pulse cyc=%0d chg=%0d status=%0d exp 0/0", i, chg, status);
            end
            step();
        end
    endtask

    task automatic test_saturation();
        hold_ticks = 16'd0; ACTIVE_CNT = 8'd15; INACTIVE_CNT = 8'd2;
        idle();
        do_reset();
        for (int k = 1; k <= 15; k++) begin
            rx_cmd = 2'b10; step();
            n_checks++;
            if (h4 !== 4'(k) || st4 !== 3'd2 || dut_vec !== exp_vec) begin
                n_errors++; $display("FAIL sat_count k=%0d h4=%0d st4=%0d main=%h exp=%h", k, h4, st4, dut_vec, exp_vec);
            end
            rx_cmd = 2'b11; step();
        end
        n_checks++;
        if (st4 !== 3'd4 || h4 !== 4'd15 || done4 !== 1'b0) begin
            n_errors++; $display("FAIL sat_active st4=%0d h4=%0d done4=%0d exp 4/15/0", st4, h4, done4);
        end
        step();
        n_checks++;
        if (st4 !== 3'd4 || h4 !== 4'd15 || done4 !== 1'b1) begin
            n_errors++; $display("FAIL sat_hold0 st4=%0d h4=%0d done4=%0d exp 4/15/1", st4, h4, done4);
        end
        step();
        n_checks++;
        if (st4 !== 3'd1 || l4 !== 4'd1 || dut_vec !== exp_vec) begin
            n_errors++; $display("FAIL sat_countdown st4=%0d l4=%0d main=%h exp=%h", st4, l4, dut_vec, exp_vec);
        end
    endtask

    task automatic test_stats();
        hold_ticks = 16'd1; ACTIVE_CNT = 8'd1; INACTIVE_CNT = 8'd1;
        idle();
        do_reset();
        for (int r = 0; r < 2; r++) begin
            rx_cmd = 2'b10; step();
            rx_cmd = 2'b11; step();
            for (int i = 0; i < 10 && st != 3'd0; i++) step();
        end
        step(); step();
        n_checks++;
        if (up !== 16'(2 * STATS_ON) || down !== 16'(2 * STATS_ON)) begin
            n_errors++; $display("FAIL stats up=%0d down=%0d exp %0d/%0d", up, down, 2 * STATS_ON, 2 * STATS_ON);
        end
        n_checks++;
        if (dut_vec !== exp_vec) begin
            n_errors++; $display("FAIL stats_model got=%h exp=%h", dut_vec, exp_vec);
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 6; s++) begin
            hold_ticks   = 16'($urandom_range(0, 5));
            ACTIVE_CNT   = 8'($urandom_range(1, 4));
            INACTIVE_CNT = 8'($urandom_range(1, 3));
            idle();
            do_reset();
            for (int c = 0; c < 300; c++) begin
                rx_cmd            = 2'($urandom_range(0, 3));
                RX_DV             = ($urandom_range(0, 7) == 0);
                CRS               = ($urandom_range(0, 1) == 1);
                an_link_good      = ($urandom_range(0, 79) != 0);
                mr_autoneg_enable = ($urandom_range(0, 149) != 0);
                multidrop         = ($urandom_range(0, 149) == 0);
                pcs_reset         = ($urandom_range(0, 249) == 0);
                if ($urandom_range(0, 31) == 0) ACTIVE_CNT = 8'($urandom_range(1, 4));
                if ($urandom_range(0, 31) == 0) INACTIVE_CNT = 8'($urandom_range(1, 3));
                step();
                n_checks++;
                if (dut_vec !== exp_vec) begin
                    n_errors++; $display("FAIL random seg=%0d cyc=%0d got=%h exp=%h", s, c, dut_vec, exp_vec);
                end
            end
            pcs_reset = 1'b0;
        end
    endtask

    initial begin
        pcs_reset = 1'b1;
        hold_ticks = 16'd4; ACTIVE_CNT = 8'd3; INACTIVE_CNT = 8'd2;
        idle();
        test_reset();
        test_activate();
        test_count_down();
        test_link_drop();
        test_hb_vs_done();
        test_saturation();
        test_stats();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/mod_147_11_sync.md
MOD_147_11_SYNC -- requirements
Module: mod_147_11_sync

Interface
REQ-001 Parameter CNT_W, default 8: width of cnt_h, cnt_l, ACTIVE_CNT and INACTIVE_CNT.
REQ-002 Parameter TMR_W, default 16: width of the link-hold timer and of hold_ticks.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 pcs_reset  in  1  synchronous, active-high reset.
REQ-005 mr_autoneg_enable, an_link_good, multidrop  in  1 each  qualifiers; any one inactive (or multidrop high) forces INACTIVE.
REQ-006 rx_cmd  in  2  BEACON=00, COMMIT=01, HEARTBEAT=10, NONE=11.
REQ-007 RX_DV, CRS  in  1 each  receive data valid and carrier sense.
REQ-008 ACTIVE_CNT, INACTIVE_CNT  in  CNT_W  thresholds, sampled every cycle.
REQ-009 hold_ticks  in  TMR_W  link_hold_timer duration in clk cycles; 0 is treated as 1.
REQ-010 mod_147_11_state  out  3  INACTIVE=000, COUNT_DOWN=001, COUNT_UP=010, HOLD_OFF=011, ACTIVE=100, HOLD_ON=101.
REQ-011 pcs_status  out  1  1=OK, 0=NOT_OK.
REQ-012 cnt_h, cnt_l  out  CNT_W  heartbeat-up and heartbeat-miss counters.
REQ-013 link_hold_timer_done  out  1  internal timer expired flag.
REQ-014 status_chg  out  1  one-cycle pulse on any pcs_status change.

Function
REQ-015 Registered FSM; next state evaluated from current registered state and inputs; entry actions are applied in the same edge that enters the state.
REQ-016 Force condition (pcs_reset | !mr_autoneg_enable | !an_link_good | multidrop) SHALL move to INACTIVE on the next edge from any state, overriding all other transitions.
REQ-017 "hb" means (rx_cmd==HEARTBEAT | RX_DV).
REQ-018 INACTIVE: entry sets pcs_status=0, cnt_h=0, cnt_l=0; hb -> COUNT_UP.
REQ-019 COUNT_UP: entry increments cnt_h (saturating at all-ones) and restarts the timer; cnt_h>=ACTIVE_CNT -> ACTIVE (highest priority); else rx_cmd==NONE & !RX_DV & !CRS -> HOLD_OFF; otherwise stay.
REQ-020 HOLD_OFF: hb -> COUNT_UP (priority); else timer_done & rx_cmd==NONE & !RX_DV -> INACTIVE.
REQ-021 ACTIVE: entry sets pcs_status=1 and restarts the timer; hb -> HOLD_ON (priority); else timer_done -> COUNT_DOWN.
REQ-022 HOLD_ON: entry clears cnt_l; rx_cmd==NONE & !RX_DV -> ACTIVE.
REQ-023 COUNT_DOWN: entry increments cnt_l (saturating); the next edge always exits: cnt_l>=INACTIVE_CNT -> INACTIVE, else -> ACTIVE.
REQ-024 Timer: restart loads 0 and clears done; counts +1 per cycle; done=1 when count reaches max(hold_ticks,1)-1 and holds until the next restart; the count does not wrap.
REQ-025 Re-entering COUNT_UP or ACTIVE (including self-looping via HOLD_OFF/HOLD_ON) restarts the timer.
REQ-026 Unused encodings 110/111 SHALL go to INACTIVE on the next edge.
REQ-027 status_chg is registered and asserted the cycle after pcs_status toggles.

Reset
REQ-028 On pcs_reset: state=INACTIVE, pcs_status=0, cnt_h=cnt_l=0, timer=0, link_hold_timer_done=0, status_chg=0, and statistics cleared.
REQ-029 Reset asserted mid-operation SHALL NOT generate a status_chg pulse.

Configuration
REQ-030 Macro PCS_STATUS_STATS_EN: when defined, adds outputs link_up_cnt and link_down_cnt (16 bits each, saturating), incremented on each 0->1 and 1->0 pcs_status transition respectively; when undefined, the ports exist and are tied to 0 with no counter logic.

Structure
REQ-031 Shared package: state encodings, rx_cmd encodings, OK/NOT_OK constants.
REQ-032 One sub-module, link_hold_tmr (TMR_W parameter, restart/hold_ticks in, done out).

Verification
REQ-033 ACTIVE_CNT=3, hold_ticks=4, three HEARTBEAT cycles each separated by NONE -> ACTIVE, pcs_status=1, status_chg pulse 1 cycle later.
REQ-034 In ACTIVE with INACTIVE_CNT=2, rx_cmd=NONE for 10 cycles -> COUNT_DOWN/ACTIVE twice, then INACTIVE with pcs_status=0.
REQ-035 In ACTIVE, an_link_good dropped for 1 cycle -> INACTIVE next edge, counters=0.
REQ-036 In ACTIVE, HEARTBEAT and timer_done on the same cycle -> HOLD_ON, not COUNT_DOWN.
REQ-037 CNT_W=4, ACTIVE_CNT=15, cnt_h held at 15 -> saturation without wrap; hold_ticks=0 behaves as 1.
REQ-038 With PCS_STATUS_STATS_EN: 2 up/down cycles -> link_up_cnt=2 and link_down_cnt=2; without the macro both read 0.
